pit_timer_core: RTL and testbench
=================================

# pit_timer_core

Register file and counting engine of the programmable interval timer. It sits directly downstream of the PIT Wishbone bus interface and consumes its byte write strobes, write data and reset outputs. It returns the 48-bit read-register image and the interrupt source to that interface. It also implements a binary prescaler, a 16-bit modulus counter, a sticky rollover flag, and a one-cycle rollover pulse output.

## Interface
- DWIDTH, 16: data bus width; legal values are 8 or 16.
- MOD_RST, 16'h0000: reset value of the modulus register.

- wb_clk_i  in  1  master clock.
- async_rst_b  in  1  reset, asynchronous, active-low; clock wb_clk_i.
- sync_reset  in  1  synchronous active-high reset; same effect as async_rst_b, applied at the next edge.
- wb_dat_i  in  DWIDTH  write data from the bus.
- write_regs  in  4  byte write strobes: [0] CTRL[7:0], [1] CTRL[15:8], [2] MOD[7:0], [3] MOD[15:8].
- read_regs  out  48  readback image: [15:0] CTRL, [31:16] MOD, [47:32] CNT.
- irq_source  out  1  level interrupt = PIT_FLAG & PIT_IRQ_EN.
- pit_o  out  1  one-cycle pulse on each counter rollover.

## Operation
- Byte data source:
  - DWIDTH==8: every strobe takes wb_dat_i[7:0].
  - DWIDTH==16: low-byte strobes ([0],[2]) take [7:0]; high-byte strobes take [15:8].
- CTRL bits:
  - bit0 PIT_EN, read/write.
  - bit1 PIT_IRQ_EN, read/write.
  - bit2 PIT_FLAG: sticky. Writing 1 via strobe[0] clears it; writing 0 has no effect.
  - bits[11:8] PRE_SEL, read/write.
  - All other bits read 0 and ignore writes.
- Prescaler:
  - 15-bit pre_cnt.
  - tick = PIT_EN & (pre_cnt == 2^PRE_SEL − 1).
  - Each cycle pre_cnt advances to 0 on tick, otherwise pre_cnt+1.
  - PRE_SEL=0 gives a tick every cycle; PRE_SEL=15 gives a tick every 32768 cycles.
- Counter:
  - 16-bit CNT increments on tick.
  - Rollover condition: tick & (CNT == MOD−1), with MOD−1 computed mod 2^16, so MOD=0 gives a period of 65536 ticks and MOD=1 rolls over on every tick.
  - On rollover: CNT←0, PIT_FLAG←1, pit_o=1 for the following cycle.
- Restart rules (each clears pre_cnt and CNT to 0 at the same edge as the write):
  - PIT_EN=0: pre_cnt and CNT are held at 0.
  - Any write to MOD (strobe[2] or [3]).
  - Any write to strobe[1], since it carries PRE_SEL.
- Simultaneous rollover and flag-clear write: set wins, so PIT_FLAG stays 1.
- Simultaneous restart write and tick: restart wins. CNT=0, and no rollover, flag or pulse.
- Reset values (async or sync):
  - CTRL=0, MOD=MOD_RST, CNT=0, pre_cnt=0.
  - pit_o=0, irq_source=0, read_regs={16'h0000, MOD_RST, 16'h0000}.
- Reset mid-count abandons the period. No pulse or flag is generated.

## Timing
- All state is updated on the rising edge of wb_clk_i. A strobe sampled high at edge k takes effect in read_regs after edge k.
- read_regs and irq_source are combinational from registers only, with no path from wb_dat_i or write_regs. pit_o is registered.
- If PIT_EN is written to 1 at edge k with PRE_SEL=0, CNT=1 after edge k+1.
- Rollover at edge r:
  - CNT=0, PIT_FLAG=1, pit_o=1 during cycle r..r+1.
  - irq_source is high from edge r if IRQ_EN=1.
- Period between pit_o pulses = max(MOD,65536·[MOD==0]) · 2^PRE_SEL cycles.
- Strobes arrive at most one per cycle per byte. Multiple strobes in one cycle (16-bit bus) are applied together.

## Structure
- Shared package pit_pkg holds:
  - CTRL bit index constants (PIT_EN, PIT_IRQ_EN, PIT_FLAG, PRE_SEL_LSB/MSB).
  - read_regs field offsets (CTRL_LSB=0, MOD_LSB=16, CNT_LSB=32).
  - write_regs strobe indices and COUNT_W=16.
- One sub-module, pit_prescaler: inputs clock, resets, enable, clear, PRE_SEL[3:0]; output tick. It contains pre_cnt and the compare.
- Register file, byte steering, counter and flag logic live in pit_timer_core.

## Test plan
- Reset: assert async_rst_b low mid-cycle -> read_regs={0,MOD_RST,0}, irq_source=0, pit_o=0 immediately; sync_reset gives the same values after the next edge.
- Basic period: DWIDTH=16, write MOD=4, then CTRL=16'h0003 -> CNT 1,2,3,0; pit_o pulses every 4 cycles; irq_source=1 after the first rollover.
- Prescale: PRE_SEL=2, MOD=3 -> pit_o period 12 cycles; a strobe[1] write mid-period restarts the period with CNT=0.
- Flag race: write CTRL with bit2=1 on the same edge as a rollover -> PIT_FLAG remains 1; a write on a later non-rollover edge -> PIT_FLAG=0, irq_source=0.
- Boundaries: MOD=1 -> pit_o high on every tick; MOD=0 with PRE_SEL=0 -> CNT reaches 16'hFFFF, then 0, with a period of 65536 cycles.
- 8-bit bus: DWIDTH=8, strobes [2] then [3] with wb_dat_i=8'h34, 8'h12 -> MOD=16'h1234; each write restarts the counter.

Source files
------------

// File: rtl/pit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pit_pkg
// Description : Shared constants, control-register type and prescaler helper
//               for the programmable interval timer core.
// Revision    : 1.0 - initial release
// ============================================================================
package pit_pkg;

    // Counter / modulus width and prescaler width
    localparam int unsigned COUNT_W     = 16;
    localparam int unsigned PRE_W       = 15;

    // CTRL register bit positions
    localparam int unsigned PIT_EN      = 0;
    localparam int unsigned PIT_IRQ_EN  = 1;
    localparam int unsigned PIT_FLAG    = 2;
    localparam int unsigned PRE_SEL_LSB = 8;
    localparam int unsigned PRE_SEL_MSB = 11;

    // Field offsets inside the 48-bit readback image
    localparam int unsigned CTRL_LSB    = 0;
    localparam int unsigned MOD_LSB     = 16;
    localparam int unsigned CNT_LSB     = 32;

    // Byte write strobe indices
    localparam int unsigned WR_CTRL_LO  = 0;
    localparam int unsigned WR_CTRL_HI  = 1;
    localparam int unsigned WR_MOD_LO   = 2;
    localparam int unsigned WR_MOD_HI   = 3;

    // Implemented CTRL fields only; everything else reads as zero
    typedef struct packed {
        logic [3:0] pre_sel;
        logic       flag;
        logic       irq_en;
        logic       en;
    } pit_ctrl_t;

    // Terminal prescaler value 2^sel - 1. For sel=15 the one-hot bit falls
    // off the top of the 15-bit word, and 0 - 1 wraps to 15'h7FFF as needed.
    function automatic logic [PRE_W-1:0] pre_limit(input logic [3:0] sel);
        logic [PRE_W-1:0] pow;
        pow = PRE_W'(1) << sel;
        return pow - PRE_W'(1);
    endfunction

    // Assemble the 16-bit CTRL readback word
    function automatic logic [COUNT_W-1:0] ctrl_image(input pit_ctrl_t c);
        logic [COUNT_W-1:0] img;
        img                           = '0;
        img[PIT_EN]                   = c.en;
        img[PIT_IRQ_EN]               = c.irq_en;
        img[PIT_FLAG]                 = c.flag;
        img[PRE_SEL_MSB:PRE_SEL_LSB]  = c.pre_sel;
        return img;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pit_timer_core_if.sv
`default_nettype none
// ============================================================================
// Module      : pit_timer_core_if
// Description : Register-access link between the PIT bus interface (master)
//               and the timer core (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pit_timer_core_if #(
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] wb_dat_i;
    logic [3:0]        write_regs;
    logic [47:0]       read_regs;
    logic              irq_source;

    modport master (
        output wb_dat_i,
        output write_regs,
        input  read_regs,
        input  irq_source
    );

    modport slave (
        input  wb_dat_i,
        input  write_regs,
        output read_regs,
        output irq_source
    );
endinterface
`default_nettype wire

// File: rtl/pit_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : pit_prescaler
// Description : Binary prescaler. Emits one tick every 2^pre_sel cycles while
//               enabled; clear restarts the division from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pit_prescaler
    import pit_pkg::*;
(
    input  wire logic       wb_clk_i,
    input  wire logic       async_rst_b,
    input  wire logic       sync_reset,
    input  wire logic       en_i,
    input  wire logic       clear_i,
    input  wire logic [3:0] pre_sel_i,
    output logic            tick_o
);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;

    assign tick_o = en_i & (pre_cnt_q == pre_limit(pre_sel_i));

    // Next prescaler value: wrap on tick, zero on clear, else advance
    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        if (clear_i || tick_o) begin
            pre_cnt_d = '0;
        end
    end

    // Prescaler state register
    always_ff @(posedge wb_clk_i or negedge async_rst_b) begin
        if (!async_rst_b) begin
            pre_cnt_q <= '0;
        end else if (sync_reset) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pit_timer_core.sv
`default_nettype none
// ============================================================================
// Module      : pit_timer_core
// Description : PIT register file and counting engine: CTRL/MOD registers
//               with byte steering, modulus counter, sticky rollover flag,
//               level interrupt and one-cycle rollover pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pit_timer_core
    import pit_pkg::*;
#(
    parameter int                 DWIDTH  = 16,
    parameter logic [COUNT_W-1:0] MOD_RST = 16'h0000
) (
    input  wire logic        wb_clk_i,
    input  wire logic        async_rst_b,
    input  wire logic        sync_reset,
    pit_timer_core_if.slave  bus,
    output logic             pit_o
);

    pit_ctrl_t          ctrl_q, ctrl_d;
    logic [COUNT_W-1:0] mod_q,  mod_d;
    logic [COUNT_W-1:0] cnt_q,  cnt_d;
    logic               pit_q,  pit_d;

    logic [7:0]         w_lo_byte;
    logic [7:0]         w_hi_byte;
    logic               w_wr_ctrl_lo;
    logic               w_wr_ctrl_hi;
    logic               w_wr_mod_lo;
    logic               w_wr_mod_hi;
    logic               w_restart;
    logic               w_clear;
    logic               w_tick;
    logic               w_cnt_tick;
    logic               w_rollover;
    logic [COUNT_W-1:0] w_mod_m1;
    logic [47:0]        w_read;

    // Low-byte strobes always use the bottom lane; high-byte strobes use the
    // upper lane only when the bus is 16 bits wide.
    assign w_lo_byte = bus.wb_dat_i[7:0];

    generate
        if (DWIDTH == 16) begin : g_bus16
            assign w_hi_byte = bus.wb_dat_i[15:8];
        end else begin : g_bus8
            assign w_hi_byte = bus.wb_dat_i[7:0];
        end
    endgenerate

    assign w_wr_ctrl_lo = bus.write_regs[WR_CTRL_LO];
    assign w_wr_ctrl_hi = bus.write_regs[WR_CTRL_HI];
    assign w_wr_mod_lo  = bus.write_regs[WR_MOD_LO];
    assign w_wr_mod_hi  = bus.write_regs[WR_MOD_HI];

    // PRE_SEL or MOD writes restart the period; a disabled timer stays parked
    assign w_restart  = w_wr_ctrl_hi | w_wr_mod_lo | w_wr_mod_hi;
    assign w_clear    = w_restart | ~ctrl_q.en;

    pit_prescaler u_prescaler (
        .wb_clk_i    (wb_clk_i),
        .async_rst_b (async_rst_b),
        .sync_reset  (sync_reset),
        .en_i        (ctrl_q.en),
        .clear_i     (w_clear),
        .pre_sel_i   (ctrl_q.pre_sel),
        .tick_o      (w_tick)
    );

    // A restart on the same edge as a tick suppresses the tick entirely
    assign w_cnt_tick = w_tick & ~w_clear;
    assign w_mod_m1   = mod_q - COUNT_W'(1);
    assign w_rollover = w_cnt_tick & (cnt_q == w_mod_m1);

    // Register writes, counter advance and flag/pulse generation
    always_comb begin
        ctrl_d = ctrl_q;
        mod_d  = mod_q;
        cnt_d  = cnt_q;
        pit_d  = 1'b0;

        if (w_wr_ctrl_lo) begin
            ctrl_d.en     = w_lo_byte[PIT_EN];
            ctrl_d.irq_en = w_lo_byte[PIT_IRQ_EN];
            if (w_lo_byte[PIT_FLAG]) begin
                ctrl_d.flag = 1'b0;
            end
        end
        if (w_wr_ctrl_hi) begin
            ctrl_d.pre_sel = w_hi_byte[PRE_SEL_MSB-8:PRE_SEL_LSB-8];
        end
        if (w_wr_mod_lo) begin
            mod_d[7:0] = w_lo_byte;
        end
        if (w_wr_mod_hi) begin
            mod_d[15:8] = w_hi_byte;
        end

        if (w_clear || w_rollover) begin
            cnt_d = '0;
        end else if (w_cnt_tick) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end

        // Set beats a simultaneous flag-clear write
        if (w_rollover) begin
            ctrl_d.flag = 1'b1;
            pit_d       = 1'b1;
        end
    end

    // Timer state registers
    always_ff @(posedge wb_clk_i or negedge async_rst_b) begin
        if (!async_rst_b) begin
            ctrl_q <= '0;
            mod_q  <= MOD_RST;
            cnt_q  <= '0;
            pit_q  <= 1'b0;
        end else if (sync_reset) begin
            ctrl_q <= '0;
            mod_q  <= MOD_RST;
            cnt_q  <= '0;
            pit_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            mod_q  <= mod_d;
            cnt_q  <= cnt_d;
            pit_q  <= pit_d;
        end
    end

    // Readback image assembled purely from register state
    always_comb begin
        w_read                       = '0;
        w_read[CTRL_LSB +: COUNT_W]  = ctrl_image(ctrl_q);
        w_read[MOD_LSB  +: COUNT_W]  = mod_q;
        w_read[CNT_LSB  +: COUNT_W]  = cnt_q;
    end

    assign bus.read_regs  = w_read;
    assign bus.irq_source = ctrl_q.flag & ctrl_q.irq_en;
    assign pit_o          = pit_q;

endmodule
`default_nettype wire

// File: tb/tb_pit_timer_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_pit_timer_core
// Description : Self-checking bench for pit_timer_core (16-bit and 8-bit bus
//               instances) using an expected-value queue for cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pit_timer_core;
    import pit_pkg::*;

    typedef struct packed {
        logic [15:0] cnt;
        logic        pit;
        logic        irq;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    logic srst;
    logic pit16;
    logic pit8;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pit_timer_core_if #(.DWIDTH(16)) bus16 ();
    pit_timer_core_if #(.DWIDTH(8))  bus8  ();

    pit_timer_core #(.DWIDTH(16), .MOD_RST(16'h0007)) dut16 (
        .wb_clk_i    (clk),
        .async_rst_b (rst_b),
        .sync_reset  (srst),
        .bus         (bus16.slave),
        .pit_o       (pit16)
    );

    pit_timer_core #(.DWIDTH(8), .MOD_RST(16'h00C3)) dut8 (
        .wb_clk_i    (clk),
        .async_rst_b (rst_b),
        .sync_reset  (srst),
        .bus         (bus8.slave),
        .pit_o       (pit8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr16(input logic [3:0] st, input logic [15:0] d);
        bus16.write_regs = st;
        bus16.wb_dat_i   = d;
        step();
        bus16.write_regs = 4'b0000;
    endtask

    task automatic wr8(input logic [3:0] st, input logic [7:0] d);
        bus8.write_regs = st;
        bus8.wb_dat_i   = d;
        step();
        bus8.write_regs = 4'b0000;
    endtask

    // Stop counting, clear flag and irq enable, PRE_SEL back to 0
    task automatic disable16();
        wr16(4'b0011, 16'h0004);
    endtask

    task automatic test_reset();
        // async assertion mid-cycle after building up state
        wr16(4'b1100, 16'h0005);
        wr16(4'b0011, 16'h0003);
        repeat (10) step();
        #3 rst_b = 1'b0;
        #1;
        n_vec++;
        if (bus16.read_regs !== {16'h0000, 16'h0007, 16'h0000} || bus16.irq_source !== 1'b0 || pit16 !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset16: regs=%h irq=%b pit=%b want regs=%h irq=0 pit=0",
                     bus16.read_regs, bus16.irq_source, pit16, {16'h0000, 16'h0007, 16'h0000});
        end
        n_vec++;
        if (bus8.read_regs !== {16'h0000, 16'h00C3, 16'h0000} || pit8 !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset8: regs=%h pit=%b want regs=%h pit=0",
                     bus8.read_regs, pit8, {16'h0000, 16'h00C3, 16'h0000});
        end
        #2 rst_b = 1'b1;
        step();

        // synchronous reset acts only at the next edge
        wr16(4'b1100, 16'h0005);
        wr16(4'b0011, 16'h0003);
        repeat (10) step();
        srst = 1'b1;
        #1;
        n_vec++;
        if (bus16.irq_source !== 1'b1) begin
            n_err++;
            $display("FAIL sync_reset_before_edge: irq=%b want 1", bus16.irq_source);
        end
        step();
        srst = 1'b0;
        n_vec++;
        if (bus16.read_regs !== {16'h0000, 16'h0007, 16'h0000} || bus16.irq_source !== 1'b0 || pit16 !== 1'b0) begin
            n_err++;
            $display("FAIL sync_reset16: regs=%h irq=%b pit=%b want regs=%h irq=0 pit=0",
                     bus16.read_regs, bus16.irq_source, pit16, {16'h0000, 16'h0007, 16'h0000});
        end
    endtask

    task automatic test_basic_period();
        exp_t e;
        wr16(4'b1100, 16'h0004);
        wr16(4'b0011, 16'h0003);
        n_vec++;
        if (bus16.read_regs[CNT_LSB +: 16] !== 16'h0000 || pit16 !== 1'b0 || bus16.read_regs[15:0] !== 16'h0003) begin
            n_err++;
            $display("FAIL basic_start: cnt=%h pit=%b ctrl=%h want cnt=0000 pit=0 ctrl=0003",
                     bus16.read_regs[CNT_LSB +: 16], pit16, bus16.read_regs[15:0]);
        end
        for (int j = 1; j <= 12; j++) begin
            e.cnt = 16'(j % 4);
            e.pit = (j % 4 == 0);
            e.irq = (j >= 4);
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step();
            n_vec++;
            if (bus16.read_regs[CNT_LSB +: 16] !== e.cnt || pit16 !== e.pit || bus16.irq_source !== e.irq) begin
                n_err++;
                $display("FAIL basic_period: cnt=%h pit=%b irq=%b want cnt=%h pit=%b irq=%b",
                         bus16.read_regs[CNT_LSB +: 16], pit16, bus16.irq_source, e.cnt, e.pit, e.irq);
            end
        end
        disable16();
    endtask

    task automatic test_prescale();
        exp_t e;
        wr16(4'b1100, 16'h0003);
        wr16(4'b0011, 16'h0201);
        for (int j = 1; j <= 24; j++) begin
            e.cnt = 16'((j / 4) % 3);
            e.pit = (j % 12 == 0);
            e.irq = 1'b0;
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step();
            n_vec++;
            if (bus16.read_regs[CNT_LSB +: 16] !== e.cnt || pit16 !== e.pit || bus16.irq_source !== e.irq) begin
                n_err++;
                $display("FAIL prescale_period: cnt=%h pit=%b irq=%b want cnt=%h pit=%b irq=%b",
                         bus16.read_regs[CNT_LSB +: 16], pit16, bus16.irq_source, e.cnt, e.pit, e.irq);
            end
        end
        repeat (6) step();
        n_vec++;
        if (bus16.read_regs[CNT_LSB +: 16] !== 16'h0001) begin
            n_err++;
            $display("FAIL prescale_midperiod: cnt=%h want 0001", bus16.read_regs[CNT_LSB +: 16]);
        end
        // PRE_SEL byte write restarts the period
        wr16(4'b0010, 16'h0200);
        n_vec++;
        if (bus16.read_regs[CNT_LSB +: 16] !== 16'h0000 || bus16.read_regs[11:8] !== 4'd2) begin
            n_err++;
            $display("FAIL prescale_restart: cnt=%h presel=%h want cnt=0000 presel=2",
                     bus16.read_regs[CNT_LSB +: 16], bus16.read_regs[11:8]);
        end
        for (int j = 1; j <= 12; j++) begin
            e.cnt = 16'((j / 4) % 3);
            e.pit = (j == 12);
            e.irq = 1'b0;
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step();
            n_vec++;
            if (bus16.read_regs[CNT_LSB +: 16] !== e.cnt || pit16 !== e.pit) begin
                n_err++;
                $display("FAIL prescale_after_restart: cnt=%h pit=%b want cnt=%h pit=%b",
                         bus16.read_regs[CNT_LSB +: 16], pit16, e.cnt, e.pit);
            end
        end
        disable16();
    endtask

    task automatic test_flag_race();
        wr16(4'b1100, 16'h0004);
        wr16(4'b0011, 16'h0003);
        repeat (3) step();
        // flag-clear write lands on the rollover edge
        wr16(4'b0001, 16'h0007);
        n_vec++;
        if (bus16.read_regs[PIT_FLAG] !== 1'b1 || bus16.irq_source !== 1'b1 || pit16 !== 1'b1) begin
            n_err++;
            $display("FAIL flag_race_set_wins: flag=%b irq=%b pit=%b want flag=1 irq=1 pit=1",
                     bus16.read_regs[PIT_FLAG], bus16.irq_source, pit16);
        end
        step();
        wr16(4'b0001, 16'h0007);
        n_vec++;
        if (bus16.read_regs[PIT_FLAG] !== 1'b0 || bus16.irq_source !== 1'b0 || bus16.read_regs[CNT_LSB +: 16] !== 16'h0002) begin
            n_err++;
            $display("FAIL flag_clear: flag=%b irq=%b cnt=%h want flag=0 irq=0 cnt=0002",
                     bus16.read_regs[PIT_FLAG], bus16.irq_source, bus16.read_regs[CNT_LSB +: 16]);
        end
        disable16();
    endtask

    task automatic test_boundaries();
        int early;
        // Modulus of one: rollover on every tick
        wr16(4'b1100, 16'h0001);
        wr16(4'b0011, 16'h0001);
        for (int j = 1; j <= 5; j++) begin
            step();
            n_vec++;
            if (pit16 !== 1'b1 || bus16.read_regs[CNT_LSB +: 16] !== 16'h0000) begin
                n_err++;
                $display("FAIL mod1: cycle=%0d pit=%b cnt=%h want pit=1 cnt=0000",
                         j, pit16, bus16.read_regs[CNT_LSB +: 16]);
            end
        end
        disable16();

        // Modulus of zero: full 65536-tick period
        wr16(4'b1100, 16'h0000);
        wr16(4'b0011, 16'h0001);
        early = 0;
        for (int j = 1; j <= 65535; j++) begin
            step();
            if (pit16 === 1'b1) early++;
        end
        n_vec++;
        if (bus16.read_regs[CNT_LSB +: 16] !== 16'hFFFF || early !== 0) begin
            n_err++;
            $display("FAIL mod0_top: cnt=%h early_pulses=%0d want cnt=ffff early_pulses=0",
                     bus16.read_regs[CNT_LSB +: 16], early);
        end
        step();
        n_vec++;
        if (bus16.read_regs[CNT_LSB +: 16] !== 16'h0000 || pit16 !== 1'b1) begin
            n_err++;
            $display("FAIL mod0_wrap: cnt=%h pit=%b want cnt=0000 pit=1",
                     bus16.read_regs[CNT_LSB +: 16], pit16);
        end
        disable16();
    endtask

    task automatic test_bus8();
        wr8(4'b0001, 8'h01);
        repeat (3) step();
        n_vec++;
        if (bus8.read_regs[CNT_LSB +: 16] !== 16'h0003) begin
            n_err++;
            $display("FAIL bus8_count: cnt=%h want 0003", bus8.read_regs[CNT_LSB +: 16]);
        end
        wr8(4'b0100, 8'h34);
        n_vec++;
        if (bus8.read_regs[MOD_LSB +: 16] !== 16'h0034 || bus8.read_regs[CNT_LSB +: 16] !== 16'h0000) begin
            n_err++;
            $display("FAIL bus8_mod_lo: mod=%h cnt=%h want mod=0034 cnt=0000",
                     bus8.read_regs[MOD_LSB +: 16], bus8.read_regs[CNT_LSB +: 16]);
        end
        repeat (2) step();
        n_vec++;
        if (bus8.read_regs[CNT_LSB +: 16] !== 16'h0002) begin
            n_err++;
            $display("FAIL bus8_recount: cnt=%h want 0002", bus8.read_regs[CNT_LSB +: 16]);
        end
        wr8(4'b1000, 8'h12);
        n_vec++;
        if (bus8.read_regs[MOD_LSB +: 16] !== 16'h1234 || bus8.read_regs[CNT_LSB +: 16] !== 16'h0000) begin
            n_err++;
            $display("FAIL bus8_mod_hi: mod=%h cnt=%h want mod=1234 cnt=0000",
                     bus8.read_regs[MOD_LSB +: 16], bus8.read_regs[CNT_LSB +: 16]);
        end
        wr8(4'b0010, 8'h03);
        n_vec++;
        if (bus8.read_regs[15:0] !== 16'h0301) begin
            n_err++;
            $display("FAIL bus8_ctrl_hi: ctrl=%h want 0301", bus8.read_regs[15:0]);
        end
    endtask

    initial begin
        rst_b            = 1'b0;
        srst             = 1'b0;
        bus16.write_regs = 4'b0000;
        bus16.wb_dat_i   = 16'h0000;
        bus8.write_regs  = 4'b0000;
        bus8.wb_dat_i    = 8'h00;
        repeat (3) step();
        rst_b = 1'b1;
        step();
        n_vec++;
        if (bus16.read_regs !== {16'h0000, 16'h0007, 16'h0000} || pit16 !== 1'b0 || bus16.irq_source !== 1'b0) begin
            n_err++;
            $display("FAIL initial_reset: regs=%h pit=%b irq=%b want regs=%h pit=0 irq=0",
                     bus16.read_regs, pit16, bus16.irq_source, {16'h0000, 16'h0007, 16'h0000});
        end
        test_reset();
        test_basic_period();
        test_prescale();
        test_flag_race();
        test_boundaries();
        test_bus8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired before completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
